// File: rtl/qcl_tx_pkg.sv
// Shared types and constants for the QCL TX lane framer.
package qcl_tx_pkg;

  typedef enum logic [1:0] {
    StHold  = 2'd0,
    StTrain = 2'd1,
    StRun   = 2'd2
  } tx_state_e;

  localparam int unsigned MaxSerRatio = 16;

  localparam logic [3:0] TrainPatternDef = 4'b1010;
  localparam logic [3:0] SyncPatternDef  = 4'b1100;
  localparam logic [3:0] IdlePatternDef  = 4'b0000;

  // Alternating 1010.. word with a 1 in the first-serialised (MSB) position.
  function automatic logic [MaxSerRatio-1:0] clk_pattern(int unsigned ratio);
    logic [MaxSerRatio-1:0] p;
    p = '0;
    for (int unsigned i = 0; i < MaxSerRatio; i++) begin
      if (i < ratio) p[i] = (i[0] != ratio[0]);
    end
    return p;
  endfunction

endpackage

// File: rtl/qcl_tx_lane_map.sv
// Per-lane bit ordering of payload words and replication of per-lane patterns.
module qcl_tx_lane_map
  import qcl_tx_pkg::*;
#(
  parameter int unsigned           lanes_p         = 16,
  parameter int unsigned           ser_ratio_p     = 4,
  parameter bit                    msb_first_p     = 1'b1,
  parameter logic [ser_ratio_p-1:0] train_pattern_p = TrainPatternDef,
  parameter logic [ser_ratio_p-1:0] sync_pattern_p  = SyncPatternDef,
  parameter logic [ser_ratio_p-1:0] idle_pattern_p  = IdlePatternDef
) (
  input  logic [lanes_p*ser_ratio_p-1:0] data_i,
  output logic [lanes_p*ser_ratio_p-1:0] data_o,
  output logic [lanes_p*ser_ratio_p-1:0] train_word_o,
  output logic [lanes_p*ser_ratio_p-1:0] sync_word_o,
  output logic [lanes_p*ser_ratio_p-1:0] idle_word_o
);

  for (genvar l = 0; l < lanes_p; l++) begin : g_lane
    assign train_word_o[l*ser_ratio_p +: ser_ratio_p] = train_pattern_p;
    assign sync_word_o[l*ser_ratio_p +: ser_ratio_p]  = sync_pattern_p;
    assign idle_word_o[l*ser_ratio_p +: ser_ratio_p]  = idle_pattern_p;

    if (msb_first_p) begin : g_msb
      assign data_o[l*ser_ratio_p +: ser_ratio_p] = data_i[l*ser_ratio_p +: ser_ratio_p];
    end else begin : g_lsb
      for (genvar b = 0; b < ser_ratio_p; b++) begin : g_bit
        assign data_o[l*ser_ratio_p + b] = data_i[l*ser_ratio_p + ser_ratio_p - 1 - b];
      end
    end
  end

endmodule

// File: rtl/qcl_tx_lane_framer.sv
// TX framing engine in front of the OSERDES wrapper: reset hold, training burst,
// then payload stream with periodic sync words.
module qcl_tx_lane_framer
  import qcl_tx_pkg::*;
#(
  parameter int unsigned            lanes_p         = 16,
  parameter int unsigned            ser_ratio_p     = 4,
  parameter int unsigned            rst_hold_p      = 8,
  parameter int unsigned            train_cycles_p  = 256,
  parameter logic [ser_ratio_p-1:0] train_pattern_p = TrainPatternDef,
  parameter logic [ser_ratio_p-1:0] sync_pattern_p  = SyncPatternDef,
  parameter logic [ser_ratio_p-1:0] idle_pattern_p  = IdlePatternDef,
  parameter int unsigned            sync_period_p   = 1024,
  parameter bit                     msb_first_p     = 1'b1
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           en_i,
  input  logic                           train_req_i,
  input  logic [lanes_p*ser_ratio_p-1:0] data_i,
  input  logic                           v_i,
  output logic                           ready_o,
  output logic [lanes_p*ser_ratio_p-1:0] data_par_o,
  output logic [ser_ratio_p-1:0]         clk_pattern_o,
  output logic                           serdes_reset_o,
  output logic                           training_o,
  output logic [1:0]                     state_o
);

  localparam int unsigned Width    = lanes_p * ser_ratio_p;
  localparam int unsigned PhaseMax = (rst_hold_p > train_cycles_p) ? rst_hold_p : train_cycles_p;
  localparam int unsigned PhaseW   = $clog2(PhaseMax + 1);
  localparam int unsigned SyncW    = (sync_period_p > 1) ? $clog2(sync_period_p) : 1;
  localparam int unsigned HoldLast = (rst_hold_p > 0) ? rst_hold_p - 1 : 0;
  localparam int unsigned SyncLast = (sync_period_p > 0) ? sync_period_p - 1 : 0;

  localparam logic [MaxSerRatio-1:0] ClkPattern = clk_pattern(ser_ratio_p);

  tx_state_e         state_q, state_d;
  logic [PhaseW-1:0] phase_q, phase_d;
  logic [SyncW-1:0]  sync_cnt_q, sync_cnt_d;
  logic              sync_due_q, sync_due_d;
  logic              serdes_reset_q, serdes_reset_d;
  logic [Width-1:0]  data_q, data_d;

  logic [Width-1:0]  mapped_data, train_word, sync_word, idle_word;
  logic              accept;

  qcl_tx_lane_map #(
    .lanes_p         (lanes_p),
    .ser_ratio_p     (ser_ratio_p),
    .msb_first_p     (msb_first_p),
    .train_pattern_p (train_pattern_p),
    .sync_pattern_p  (sync_pattern_p),
    .idle_pattern_p  (idle_pattern_p)
  ) u_lane_map (
    .data_i       (data_i),
    .data_o       (mapped_data),
    .train_word_o (train_word),
    .sync_word_o  (sync_word),
    .idle_word_o  (idle_word)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q        <= StHold;
      phase_q        <= '0;
      sync_cnt_q     <= '0;
      sync_due_q     <= 1'b0;
      serdes_reset_q <= 1'b1;
      data_q         <= '0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      sync_cnt_q     <= sync_cnt_d;
      sync_due_q     <= sync_due_d;
      serdes_reset_q <= serdes_reset_d;
      data_q         <= data_d;
    end
  end

  assign accept = v_i & ready_o;

  // In TRAIN, phase counts train words already emitted; entry from HOLD emits the first one.
  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    sync_cnt_d     = sync_cnt_q;
    serdes_reset_d = serdes_reset_q;
    data_d         = idle_word;
    unique case (state_q)
      StHold: begin
        data_d = '0;
        if (phase_q == PhaseW'(HoldLast)) begin
          state_d        = StTrain;
          phase_d        = PhaseW'(1);
          serdes_reset_d = 1'b0;
          data_d         = train_word;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      StTrain: begin
        if (phase_q == PhaseW'(train_cycles_p)) begin
          state_d    = StRun;
          phase_d    = '0;
          sync_cnt_d = '0;
          data_d     = idle_word;
        end else begin
          phase_d = phase_q + 1'b1;
          data_d  = train_word;
        end
      end
      StRun: begin
        if (accept) begin
          data_d = mapped_data;
        end else if (sync_due_q) begin
          data_d = sync_word;
        end
        sync_cnt_d = sync_due_q ? '0 : sync_cnt_q + 1'b1;
        if (train_req_i) begin
          state_d = StTrain;
          phase_d = '0;
        end
      end
      default: begin
        state_d = StHold;
        phase_d = '0;
      end
    endcase
    sync_due_d = (sync_period_p != 0) && (state_d == StRun) && (sync_cnt_d == SyncW'(SyncLast));
  end

  always_comb begin
    ready_o    = (state_q == StRun) & en_i & ~sync_due_q;
    training_o = (state_q == StTrain);
    state_o    = state_q;
  end

  assign data_par_o     = data_q;
  assign serdes_reset_o = serdes_reset_q;
  assign clk_pattern_o  = ClkPattern[ser_ratio_p-1:0];

endmodule

// File: tb/tb_qcl_tx_lane_framer.sv
// Bench for qcl_tx_lane_framer: reference model plus directed and table-driven scenarios.
module tb_qcl_tx_lane_framer;

  localparam int unsigned Lanes  = 16;
  localparam int unsigned Ratio  = 4;
  localparam int unsigned Hold   = 8;
  localparam int unsigned TrainC = 16;
  localparam int unsigned SyncP  = 32;
  localparam int unsigned W      = Lanes * Ratio;

  localparam logic [63:0] TrainW = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] SyncW  = 64'hCCCC_CCCC_CCCC_CCCC;
  localparam logic [63:0] IdleW  = 64'h0;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         en = 1'b0, treq = 1'b0, v = 1'b0;
  logic [W-1:0] data = '0;

  logic         ready_m, sr_m, trn_m;
  logic [W-1:0] dpar_m;
  logic [3:0]   clkp_m;
  logic [1:0]   st_m;
  logic         ready_l, sr_l, trn_l;
  logic [W-1:0] dpar_l;
  logic [3:0]   clkp_l;
  logic [1:0]   st_l;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  qcl_tx_lane_framer #(
    .lanes_p(Lanes), .ser_ratio_p(Ratio), .rst_hold_p(Hold), .train_cycles_p(TrainC),
    .train_pattern_p(4'b1010), .sync_pattern_p(4'b1100), .idle_pattern_p(4'b0000),
    .sync_period_p(SyncP), .msb_first_p(1'b1)
  ) u_dut (
    .clk_i(clk), .reset_n_i(reset_n), .en_i(en), .train_req_i(treq), .data_i(data),
    .v_i(v), .ready_o(ready_m), .data_par_o(dpar_m), .clk_pattern_o(clkp_m),
    .serdes_reset_o(sr_m), .training_o(trn_m), .state_o(st_m)
  );

  qcl_tx_lane_framer #(
    .lanes_p(Lanes), .ser_ratio_p(Ratio), .rst_hold_p(Hold), .train_cycles_p(TrainC),
    .train_pattern_p(4'b1010), .sync_pattern_p(4'b1100), .idle_pattern_p(4'b0000),
    .sync_period_p(SyncP), .msb_first_p(1'b0)
  ) u_dut_lsb (
    .clk_i(clk), .reset_n_i(reset_n), .en_i(en), .train_req_i(treq), .data_i(data),
    .v_i(v), .ready_o(ready_l), .data_par_o(dpar_l), .clk_pattern_o(clkp_l),
    .serdes_reset_o(sr_l), .training_o(trn_l), .state_o(st_l)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] rev_lanes(input logic [63:0] d);
    logic [63:0] r;
    for (int l = 0; l < 16; l++)
      for (int b = 0; b < 4; b++) r[l*4 + b] = d[l*4 + 3 - b];
    return r;
  endfunction

  // Reference model: phase 0 hold, 1 train, 2 run.
  int          m_phase, m_hold, m_train, m_run;
  bit          m_sr;
  logic [63:0] m_msb, m_lsb;

  function automatic bit m_due();
    return (m_phase == 2) && (SyncP != 0) && ((m_run % SyncP) == SyncP - 1);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_hold = 0; m_train = 0; m_run = 0; m_sr = 1'b1;
    m_msb = '0; m_lsb = '0;
  endtask

  task automatic model_step();
    bit due, acc;
    case (m_phase)
      0: begin
        m_hold++;
        m_msb = '0; m_lsb = '0;
        if (m_hold == Hold) begin
          m_phase = 1; m_train = 1; m_sr = 1'b0; m_msb = TrainW; m_lsb = TrainW;
        end
      end
      1: begin
        if (m_train == TrainC) begin
          m_phase = 2; m_run = 0; m_msb = IdleW; m_lsb = IdleW;
        end else begin
          m_train++; m_msb = TrainW; m_lsb = TrainW;
        end
      end
      default: begin
        due = m_due();
        acc = en && v && !due;
        if (acc) begin
          m_msb = data; m_lsb = rev_lanes(data);
        end else if (due) begin
          m_msb = SyncW; m_lsb = SyncW;
        end else begin
          m_msb = IdleW; m_lsb = IdleW;
        end
        if (treq) begin
          m_phase = 1; m_train = 0;
        end else begin
          m_run++;
        end
      end
    endcase
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_step();
    #1;
    if (chk_en) begin
      check("state", 64'(st_m), 64'(m_phase));
      check("serdes_reset", 64'(sr_m), 64'(m_sr));
      check("training", 64'(trn_m), 64'(m_phase == 1));
      check("ready", 64'(ready_m), 64'((m_phase == 2) && en && !m_due()));
      check("data_par", dpar_m, m_msb);
      check("data_par_lsb", dpar_l, m_lsb);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  typedef struct {
    logic [63:0] d;
    logic [63:0] exp_msb;
    logic [63:0] exp_lsb;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int cnt, syncs, idles, accs, guard;
    bit acc;
    logic [63:0] prev;

    vecs[0] = '{64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111, 64'h8888_8888_8888_8888};
    vecs[1] = '{64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 64'h084C_2A6E_195D_3B7F};
    vecs[2] = '{64'hFFFF_0000_AAAA_5555, 64'hFFFF_0000_AAAA_5555, 64'hFFFF_0000_5555_AAAA};
    vecs[3] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'h84C2_A6E1_95D3_B7F0};
    vecs[4] = '{64'hCCCC_CCCC_CCCC_CCCC, 64'hCCCC_CCCC_CCCC_CCCC, 64'h3333_3333_3333_3333};

    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk_en = 1'b1;
    check("reset_data", dpar_m, 64'h0);
    check("reset_serdes", 64'(sr_m), 64'h1);
    check("reset_ready", 64'(ready_m), 64'h0);
    check("clk_pattern", 64'(clkp_m), 64'hA);

    // Hold phase length after reset release.
    reset_n = 1'b1;
    cnt = 0;
    while (sr_m && cnt < 100) begin
      check("hold_data", dpar_m, 64'h0);
      tick();
      cnt++;
    end
    check("hold_len", 64'(cnt), 64'(Hold));
    check("state_train", 64'(st_m), 64'h1);

    // Training burst.
    en = 1'b1;
    cnt = 0;
    while (trn_m && cnt < 100) begin
      check("train_word", dpar_m, TrainW);
      check("train_ready", 64'(ready_m), 64'h0);
      tick();
      cnt++;
    end
    check("train_len", 64'(cnt), 64'(TrainC));
    check("state_run", 64'(st_m), 64'h2);
    check("run_ready", 64'(ready_m), 64'h1);

    // Streaming with incrementing data and sync insertion.
    v = 1'b1;
    data = 64'h1;
    syncs = 0; accs = 0;
    for (int i = 0; i < 70; i++) begin
      acc = ready_m && v;
      prev = data;
      tick();
      if (acc) begin
        accs++;
        check("stream_word", dpar_m, prev);
        data = data + 1;
      end
      if (dpar_m == SyncW) syncs++;
    end
    check("stream_syncs", 64'(syncs), 64'h2);
    check("stream_accepted", 64'(accs), 64'd68);
    check("stream_next", data, 64'd69);

    // Idle with sync words still periodic.
    v = 1'b0;
    syncs = 0; idles = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (dpar_m == SyncW) syncs++;
      if (dpar_m == IdleW) idles++;
    end
    check("idle_syncs", 64'(syncs), 64'h2);
    check("idle_words", 64'(idles), 64'd62);

    // Beat accepted on the retrain edge still goes out.
    guard = 0;
    while (!ready_m && guard < 40) begin
      tick();
      guard++;
    end
    check("retrain_ready_wait", 64'(ready_m), 64'h1);
    data = 64'hDEAD_BEEF_0123_4567;
    v = 1'b1;
    treq = 1'b1;
    tick();
    treq = 1'b0;
    v = 1'b0;
    check("retrain_beat", dpar_m, 64'hDEAD_BEEF_0123_4567);
    check("retrain_ready", 64'(ready_m), 64'h0);
    check("retrain_training", 64'(trn_m), 64'h1);
    cnt = 0; guard = 0;
    while (trn_m && guard < 100) begin
      check("retrain_ready_low", 64'(ready_m), 64'h0);
      tick();
      guard++;
      if (dpar_m == TrainW) cnt++;
    end
    check("retrain_words", 64'(cnt), 64'(TrainC));
    check("retrain_run", 64'(st_m), 64'h2);

    // Lane-mapping vectors on both bit orders.
    for (int i = 0; i < 5; i++) begin
      guard = 0;
      while (!ready_m && guard < 40) begin
        tick();
        guard++;
      end
      data = vecs[i].d;
      v = 1'b1;
      tick();
      v = 1'b0;
      check("vec_msb", dpar_m, vecs[i].exp_msb);
      check("vec_lsb", dpar_l, vecs[i].exp_lsb);
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      en   = ($urandom_range(0, 3) != 0);
      v    = $urandom_range(0, 1) == 1;
      treq = ($urandom_range(0, 63) == 0);
      data = {$urandom, $urandom};
      tick();
    end
    treq = 1'b0;

    // Mid-stream reset.
    en = 1'b1; v = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    reset_n = 1'b0;
    #3;
    check("midrst_state", 64'(st_m), 64'h0);
    check("midrst_serdes", 64'(sr_m), 64'h1);
    check("midrst_data", dpar_m, 64'h0);
    check("midrst_data_lsb", dpar_l, 64'h0);
    check("midrst_ready", 64'(ready_m), 64'h0);
    check("midrst_training", 64'(trn_m), 64'h0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (40) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
